// File: rtl/bp_pkg.sv
// Shared branch-predictor definitions: 2-bit counter encoding, default history width, init FSM states.
package bp_pkg;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  localparam int HIST_W_DEF = 2;

  typedef enum logic {INIT, RUN} pht_state_t;

endpackage

// File: rtl/sat_counter2.sv
// Next value of a 2-bit saturating counter stepped toward the branch outcome.
// Purely combinational; no handshake.
module sat_counter2
  import bp_pkg::*;
(
  input  logic [1:0] cur,
  input  logic       taken,
  output logic [1:0] nxt
);

  always_comb begin
    nxt = cur;
    if (taken) begin
      if (cur != ST) nxt = cur + 2'd1;
    end else begin
      if (cur != SNT) nxt = cur - 2'd1;
    end
  end

endmodule

// File: rtl/pht_predictor.sv
// GAp pattern history table: combinational fetch prediction, 1-cycle execute training, no backpressure.
// Self-initialises to weak-not-taken after reset; PHT_BYPASS_EN forwards same-index updates to fetch.
module pht_predictor
  import bp_pkg::*;
#(
  parameter int HIST_W   = HIST_W_DEF,
  parameter int PC_IDX_W = 4
)
(
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       pcF,
  input  logic [HIST_W-1:0] historyF,
  output logic              predictTakenF,
  output logic              ready,
  input  logic              branchE,
  input  logic              isTakenE,
  input  logic [31:0]       pcE,
  input  logic [HIST_W-1:0] historyE,
  input  logic              predTakenE,
  output logic              mispredictE
);

  localparam int IDX_W = HIST_W + PC_IDX_W;
  localparam int DEPTH = 1 << IDX_W;

  pht_state_t       state;
  logic [IDX_W-1:0] init_idx;
  logic [IDX_W-1:0] idx_f;
  logic [IDX_W-1:0] idx_e;
  logic [IDX_W-1:0] wr_idx;
  logic [1:0]       wr_dat;
  logic             wr_en;
  logic [1:0]       cur_e;
  logic [1:0]       nxt_e;
  logic [1:0]       tbl [DEPTH];
  logic             unused_pc;

  assign idx_f = {historyF, pcF[PC_IDX_W+1:2]};
  assign idx_e = {historyE, pcE[PC_IDX_W+1:2]};
  assign unused_pc = ^{pcF[31:PC_IDX_W+2], pcF[1:0], pcE[31:PC_IDX_W+2], pcE[1:0]};

  assign cur_e = tbl[idx_e];

  sat_counter2 u_upd (
    .cur   (cur_e),
    .taken (isTakenE),
    .nxt   (nxt_e)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= INIT;
      init_idx <= '0;
      ready    <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          init_idx <= init_idx + 1'b1;
          if (init_idx == IDX_W'(DEPTH - 1)) begin
            state <= RUN;
            ready <= 1'b1;
          end
        end
        RUN:     ready <= 1'b1;
        default: state <= INIT;
      endcase
    end
  end

  // Single write port shared by the init sweep and branch training.
  always_comb begin
    wr_en  = 1'b0;
    wr_idx = init_idx;
    wr_dat = WNT;
    if (!reset) begin
      if (state == INIT) begin
        wr_en = 1'b1;
      end else if (ready && branchE) begin
        wr_en  = 1'b1;
        wr_idx = idx_e;
        wr_dat = nxt_e;
      end
    end
  end

  // Contents are deliberately not reset; the INIT sweep rewrites every entry.
  always_ff @(posedge clk) begin
    if (wr_en) tbl[wr_idx] <= wr_dat;
  end

`ifdef PHT_BYPASS_EN
  assign predictTakenF = ready & ((branchE && (idx_f == idx_e)) ? nxt_e[1] : tbl[idx_f][1]);
`else
  assign predictTakenF = ready & tbl[idx_f][1];
`endif

  assign mispredictE = ready & branchE & (predTakenE != isTakenE);

endmodule

// File: tb/tb_pht_predictor.sv
// Bench for pht_predictor: fixed vectors, hand corner sequences and random traffic vs. a counter-array model.
module tb_pht_predictor;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pcF, pcE;
  logic [1:0]  historyF, historyE;
  logic        branchE, isTakenE, predTakenE;
  logic        predictTakenF, ready, mispredictE;

  int total = 0;
  int bad   = 0;

  int mtab [64];
  bit mready;
  int icnt;

  typedef struct {
    logic [31:0] pc_f;
    logic [1:0]  h_f;
    logic        br;
    logic        tk;
    logic [31:0] pc_e;
    logic [1:0]  h_e;
    logic        pt;
    logic        exp_pred;
    logic        exp_misp;
  } vec_t;

  vec_t vecs [6];

`ifdef PHT_BYPASS_EN
  localparam logic COLL_EXP = 1'b1;
`else
  localparam logic COLL_EXP = 1'b0;
`endif

  pht_predictor dut (
    .clk           (clk),
    .reset         (reset),
    .pcF           (pcF),
    .historyF      (historyF),
    .predictTakenF (predictTakenF),
    .ready         (ready),
    .branchE       (branchE),
    .isTakenE      (isTakenE),
    .pcE           (pcE),
    .historyE      (historyE),
    .predTakenE    (predTakenE),
    .mispredictE   (mispredictE)
  );

  always #5 clk = ~clk;

  function automatic int idx_of(input logic [31:0] pc, input logic [1:0] h);
    return int'(h) * 16 + int'(pc[5:2]);
  endfunction

  function automatic int step(input int c, input logic tk);
    if (tk) return (c < 3) ? c + 1 : 3;
    return (c > 0) ? c - 1 : 0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle, compare outputs against the model, then clock the edge.
  task automatic apply(input logic [31:0] pf, input logic [1:0] hf, input logic br, input logic tk,
                       input logic [31:0] pe, input logic [1:0] he, input logic pt,
                       output logic act_pred, output logic act_misp);
    int  i_f, i_e;
    logic ep, em;
    pcF = pf; historyF = hf; branchE = br; isTakenE = tk;
    pcE = pe; historyE = he; predTakenE = pt;
    #2;
    i_f = idx_of(pf, hf);
    i_e = idx_of(pe, he);
    ep = 1'b0;
    if (mready) begin
      ep = (mtab[i_f] >= 2);
`ifdef PHT_BYPASS_EN
      if (br && i_f == i_e) ep = (step(mtab[i_e], tk) >= 2);
`endif
    end
    em = mready && br && (pt != tk);
    chk("pred", predictTakenF, ep);
    chk("misp", mispredictE, em);
    chk("ready", ready, mready);
    act_pred = predictTakenF;
    act_misp = mispredictE;
    if (reset) begin
      mready = 0;
      icnt   = 0;
    end else if (!mready) begin
      mtab[icnt] = 1;
      icnt++;
      if (icnt == 64) mready = 1;
    end else if (br) begin
      mtab[i_e] = step(mtab[i_e], tk);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic rand_cycle(input logic allow_br, output logic p, output logic m);
    logic [31:0] pf, pe;
    logic [1:0]  hf, he;
    pf = ($urandom & ~32'h3C) | (32'($urandom_range(0, 15)) << 2);
    hf = 2'($urandom);
    pe = ($urandom & ~32'h3C) | (32'($urandom_range(0, 15)) << 2);
    he = 2'($urandom);
    if ($urandom_range(0, 3) == 0) begin
      pe = pf;
      he = hf;
    end
    apply(pf, hf, allow_br & 1'($urandom), 1'($urandom), pe, he, 1'($urandom), p, m);
  endtask

  task automatic init_sequence(input string tag);
    logic p, m;
    for (int k = 0; k < 64; k++) begin
      rand_cycle(1'b1, p, m);
      chk({tag, "_ready_edge"}, ready, (k == 63));
    end
  endtask

  initial begin
    logic p, m;
    vecs[0] = '{32'h20, 2'b00, 1, 1, 32'h10, 2'b01, 0, 0, 1};
    vecs[1] = '{32'h20, 2'b00, 1, 1, 32'h10, 2'b01, 1, 0, 0};
    vecs[2] = '{32'h10, 2'b01, 0, 0, 32'h10, 2'b01, 1, 1, 0};
    vecs[3] = '{32'h10, 2'b00, 0, 0, 32'h10, 2'b01, 1, 0, 0};
    vecs[4] = '{32'h20, 2'b00, 1, 0, 32'h30, 2'b00, 1, 0, 1};
    vecs[5] = '{32'h30, 2'b00, 0, 0, 32'h30, 2'b00, 1, 0, 0};

    for (int i = 0; i < 64; i++) mtab[i] = 0;
    mready = 0;
    icnt = 0;
    pcF = '0; historyF = '0; branchE = 0; isTakenE = 0;
    pcE = '0; historyE = '0; predTakenE = 0;

    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("reset_ready", ready, 1'b0);
    reset = 1'b0;
    init_sequence("init");

    for (int i = 0; i < 64; i++) begin
      apply(32'(i % 16) << 2, 2'(i / 16), 0, 0, 32'h0, 2'b00, 0, p, m);
      chk("post_init_pred", p, 1'b0);
    end

    for (int i = 0; i < 6; i++) begin
      apply(vecs[i].pc_f, vecs[i].h_f, vecs[i].br, vecs[i].tk,
            vecs[i].pc_e, vecs[i].h_e, vecs[i].pt, p, m);
      chk($sformatf("vec%0d_pred", i), p, vecs[i].exp_pred);
      chk($sformatf("vec%0d_misp", i), m, vecs[i].exp_misp);
    end

    for (int i = 0; i < 10; i++) apply(32'h0, 2'b00, 1, 1, 32'h24, 2'b10, 1, p, m);
    apply(32'h24, 2'b10, 1, 0, 32'h24, 2'b10, 1, p, m);
    chk("sat_hi_read", p, 1'b1);
    apply(32'h24, 2'b10, 0, 0, 32'h0, 2'b00, 0, p, m);
    chk("sat_after_1nt", p, 1'b1);
    for (int i = 0; i < 2; i++) apply(32'h0, 2'b00, 1, 0, 32'h24, 2'b10, 0, p, m);
    apply(32'h24, 2'b10, 0, 0, 32'h0, 2'b00, 0, p, m);
    chk("sat_after_3nt", p, 1'b0);
    for (int i = 0; i < 4; i++) apply(32'h0, 2'b00, 1, 0, 32'h24, 2'b10, 0, p, m);
    apply(32'h0, 2'b00, 1, 1, 32'h24, 2'b10, 0, p, m);
    apply(32'h24, 2'b10, 0, 0, 32'h0, 2'b00, 0, p, m);
    chk("sat_lo_one_up", p, 1'b0);
    apply(32'h0, 2'b00, 1, 1, 32'h24, 2'b10, 0, p, m);
    apply(32'h24, 2'b10, 0, 0, 32'h0, 2'b00, 0, p, m);
    chk("sat_lo_two_up", p, 1'b1);

    apply(32'h3C, 2'b11, 1, 1, 32'h3C, 2'b11, 0, p, m);
    chk("collision_same_cycle", p, COLL_EXP);
    chk("collision_misp", m, 1'b1);
    apply(32'h3C, 2'b11, 0, 0, 32'h3C, 2'b11, 0, p, m);
    chk("collision_next_cycle", p, 1'b1);

    for (int i = 0; i < 300; i++) rand_cycle(1'b1, p, m);

    reset = 1'b1;
    apply(32'h10, 2'b01, 0, 0, 32'h0, 2'b00, 0, p, m);
    chk("rst_run_ready", ready, 1'b0);
    reset = 1'b0;
    for (int i = 0; i < 30; i++) rand_cycle(1'b1, p, m);
    reset = 1'b1;
    apply(32'h10, 2'b01, 1, 0, 32'h10, 2'b01, 1, p, m);
    chk("rst_mid_init_ready", ready, 1'b0);
    reset = 1'b0;
    init_sequence("reinit");
    apply(32'h10, 2'b01, 0, 0, 32'h0, 2'b00, 0, p, m);
    chk("trained_cleared_a", p, 1'b0);
    apply(32'h3C, 2'b11, 0, 0, 32'h0, 2'b00, 0, p, m);
    chk("trained_cleared_b", p, 1'b0);

    for (int i = 0; i < 200; i++) rand_cycle(1'b1, p, m);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
